// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port between the ip, lsp and md units.
// The winner is captured into a registered output slot that is held until downstream accepts it.
module wb_arbiter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] ip_wb_dst,
  input  logic [XLEN-1:0] ip_wb_result,
  input  logic [XLEN-1:0] ip_wb_pc,
  input  logic            ip_wb_wb_en,
  input  logic            ip_wb_valid,
  output logic            ip_wb_ready,
  input  logic [REGW-1:0] lsp_wb_dst,
  input  logic [XLEN-1:0] lsp_wb_result,
  input  logic [XLEN-1:0] lsp_wb_pc,
  input  logic            lsp_wb_wb_en,
  input  logic            lsp_wb_valid,
  output logic            lsp_wb_ready,
  input  logic [REGW-1:0] md_wb_dst,
  input  logic [XLEN-1:0] md_wb_result,
  input  logic [XLEN-1:0] md_wb_pc,
  input  logic            md_wb_wb_en,
  input  logic            md_wb_valid,
  output logic            md_wb_ready,
  output logic [REGW-1:0] wb_ix_dst,
  output logic [XLEN-1:0] wb_ix_result,
  output logic [XLEN-1:0] wb_ix_pc,
  output logic            wb_ix_wb_en,
  output logic [1:0]      wb_ix_src,
  output logic            wb_ix_valid,
  input  logic            wb_ix_ready
);

  localparam int unsigned NSRC = 3;
  localparam logic [1:0] SRC_IP  = 2'd0;
  localparam logic [1:0] SRC_LSP = 2'd1;
  localparam logic [1:0] SRC_MD  = 2'd2;

  logic            wb_ix_valid_q, wb_ix_valid_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [REGW-1:0] dst_q, dst_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            wb_en_q, wb_en_d;
  logic [1:0]      src_q, src_d;

  logic [NSRC-1:0] src_valid_c;
  logic [NSRC-1:0] grant_c;
  logic            can_accept_c;
  logic            grant_any_c;
  logic [1:0]      grant_id_c;
  logic [1:0]      scan_idx_c;

  assign src_valid_c  = {md_wb_valid, lsp_wb_valid, ip_wb_valid};
  assign can_accept_c = !wb_ix_valid_q || wb_ix_ready;

  // Round-robin scan starting just after the last winner, wrapping md -> ip.
  always_comb begin
    grant_any_c = 1'b0;
    grant_id_c  = SRC_IP;
    scan_idx_c  = (last_grant_q == SRC_MD) ? SRC_IP : last_grant_q + 2'd1;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!grant_any_c && src_valid_c[scan_idx_c]) begin
        grant_any_c = 1'b1;
        grant_id_c  = scan_idx_c;
      end
      scan_idx_c = (scan_idx_c == SRC_MD) ? SRC_IP : scan_idx_c + 2'd1;
    end
    if (rst || !can_accept_c) begin
      grant_any_c = 1'b0;
    end
    grant_c = grant_any_c ? (NSRC'(1) << grant_id_c) : '0;
  end

  assign ip_wb_ready  = grant_c[SRC_IP];
  assign lsp_wb_ready = grant_c[SRC_LSP];
  assign md_wb_ready  = grant_c[SRC_MD];

  // Slot load / drain / hold.
  always_comb begin
    wb_ix_valid_d = wb_ix_valid_q;
    last_grant_d  = last_grant_q;
    dst_d         = dst_q;
    result_d      = result_q;
    pc_d          = pc_q;
    wb_en_d       = wb_en_q;
    src_d         = src_q;
    if (can_accept_c) begin
      wb_ix_valid_d = grant_any_c;
      if (grant_any_c) begin
        last_grant_d = grant_id_c;
        src_d        = grant_id_c;
        case (grant_id_c)
          SRC_LSP: begin
            dst_d    = lsp_wb_dst;
            result_d = lsp_wb_result;
            pc_d     = lsp_wb_pc;
            wb_en_d  = lsp_wb_wb_en;
          end
          SRC_MD: begin
            dst_d    = md_wb_dst;
            result_d = md_wb_result;
            pc_d     = md_wb_pc;
            wb_en_d  = md_wb_wb_en;
          end
          default: begin
            dst_d    = ip_wb_dst;
            result_d = ip_wb_result;
            pc_d     = ip_wb_pc;
            wb_en_d  = ip_wb_wb_en;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ix_valid_q <= 1'b0;
      last_grant_q  <= SRC_MD;
    end else begin
      wb_ix_valid_q <= wb_ix_valid_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // Payload is qualified by wb_ix_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    dst_q    <= dst_d;
    result_q <= result_d;
    pc_q     <= pc_d;
    wb_en_q  <= wb_en_d;
    src_q    <= src_d;
  end

  assign wb_ix_valid  = wb_ix_valid_q;
  assign wb_ix_dst    = dst_q;
  assign wb_ix_result = result_q;
  assign wb_ix_pc     = pc_q;
  assign wb_ix_wb_en  = wb_en_q;
  assign wb_ix_src    = src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-free round-robin reference model.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned REGW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            wb_ix_ready;
  logic [REGW-1:0] s_dst [3];
  logic [XLEN-1:0] s_res [3];
  logic [XLEN-1:0] s_pc  [3];
  logic            s_en  [3];
  logic            s_v   [3];
  logic            s_rdy [3];

  logic [REGW-1:0] wb_ix_dst;
  logic [XLEN-1:0] wb_ix_result;
  logic [XLEN-1:0] wb_ix_pc;
  logic            wb_ix_wb_en;
  logic [1:0]      wb_ix_src;
  logic            wb_ix_valid;

  wb_arbiter #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .ip_wb_dst(s_dst[0]), .ip_wb_result(s_res[0]), .ip_wb_pc(s_pc[0]),
    .ip_wb_wb_en(s_en[0]), .ip_wb_valid(s_v[0]), .ip_wb_ready(s_rdy[0]),
    .lsp_wb_dst(s_dst[1]), .lsp_wb_result(s_res[1]), .lsp_wb_pc(s_pc[1]),
    .lsp_wb_wb_en(s_en[1]), .lsp_wb_valid(s_v[1]), .lsp_wb_ready(s_rdy[1]),
    .md_wb_dst(s_dst[2]), .md_wb_result(s_res[2]), .md_wb_pc(s_pc[2]),
    .md_wb_wb_en(s_en[2]), .md_wb_valid(s_v[2]), .md_wb_ready(s_rdy[2]),
    .wb_ix_dst(wb_ix_dst), .wb_ix_result(wb_ix_result), .wb_ix_pc(wb_ix_pc),
    .wb_ix_wb_en(wb_ix_wb_en), .wb_ix_src(wb_ix_src), .wb_ix_valid(wb_ix_valid),
    .wb_ix_ready(wb_ix_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: slot contents plus the id of the last winner.
  bit              chk_en = 1'b0;
  bit              m_valid = 1'b0;
  int              m_last = 2;
  logic [REGW-1:0] m_dst;
  logic [XLEN-1:0] m_res;
  logic [XLEN-1:0] m_pc;
  logic            m_en;
  int              m_src;
  bit              hs [3] = '{0, 0, 0};

  always @(negedge clk) begin
    int  winner;
    bit  can;
    can    = !m_valid || (wb_ix_ready === 1'b1);
    winner = -1;
    if (rst !== 1'b1 && can) begin
      for (int k = 1; k <= 3; k++) begin
        int s;
        s = (m_last + k) % 3;
        if (winner < 0 && s_v[s] === 1'b1) winner = s;
      end
    end
    if (chk_en) begin
      chk("ip_wb_ready", 64'(s_rdy[0]), 64'(winner == 0));
      chk("lsp_wb_ready", 64'(s_rdy[1]), 64'(winner == 1));
      chk("md_wb_ready", 64'(s_rdy[2]), 64'(winner == 2));
      chk("wb_ix_valid", 64'(wb_ix_valid), 64'(m_valid));
      if (m_valid) begin
        chk("wb_ix_dst", 64'(wb_ix_dst), 64'(m_dst));
        chk("wb_ix_result", wb_ix_result, m_res);
        chk("wb_ix_pc", wb_ix_pc, m_pc);
        chk("wb_ix_wb_en", 64'(wb_ix_wb_en), 64'(m_en));
        chk("wb_ix_src", 64'(wb_ix_src), 64'(m_src));
      end
    end
    for (int s = 0; s < 3; s++) hs[s] = (winner == s);
    if (rst === 1'b1) begin
      m_valid = 1'b0;
      m_last  = 2;
    end else if (can) begin
      if (winner >= 0) begin
        m_valid = 1'b1;
        m_dst   = s_dst[winner];
        m_res   = s_res[winner];
        m_pc    = s_pc[winner];
        m_en    = s_en[winner];
        m_src   = winner;
        m_last  = winner;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Advance one clock; sources whose offer was taken drop valid.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) if (hs[s]) s_v[s] = 1'b0;
  endtask

  task automatic offer(input int s, input logic [REGW-1:0] d, input logic [XLEN-1:0] r,
                       input logic [XLEN-1:0] p, input logic e);
    if (!s_v[s]) begin
      s_dst[s] = d; s_res[s] = r; s_pc[s] = p; s_en[s] = e; s_v[s] = 1'b1;
    end
  endtask

  task automatic offer_rand(input int s);
    offer(s, REGW'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endtask

  logic [1:0] exp_seq [4];

  initial begin
    rst = 1'b1;
    wb_ix_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      s_v[s] = 1'b0; s_dst[s] = '0; s_res[s] = '0; s_pc[s] = '0; s_en[s] = 1'b0;
    end
    offer(0, 5'd1, 64'h11, 64'h100, 1'b1);
    offer(1, 5'd2, 64'h22, 64'h200, 1'b1);
    offer(2, 5'd3, 64'h33, 64'h300, 1'b1);

    // Reset with everyone valid
    cyc();
    chk_en = 1'b1;
    #1;
    chk("rst_ip_ready", 64'(s_rdy[0]), 64'd0);
    chk("rst_lsp_ready", 64'(s_rdy[1]), 64'd0);
    chk("rst_md_ready", 64'(s_rdy[2]), 64'd0);
    chk("rst_valid", 64'(wb_ix_valid), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_ip_ready", 64'(s_rdy[0]), 64'd1);
    chk("post_rst_lsp_ready", 64'(s_rdy[1]), 64'd0);

    // Rotation ip -> lsp -> md, then drain
    cyc(); #1;
    chk("rot_valid0", 64'(wb_ix_valid), 64'd1);
    chk("rot_src0", 64'(wb_ix_src), 64'd0);
    chk("rot_pc0", wb_ix_pc, 64'h100);
    cyc(); #1;
    chk("rot_pc1", wb_ix_pc, 64'h200);
    cyc(); #1;
    chk("rot_pc2", wb_ix_pc, 64'h300);
    cyc(); #1;
    chk("rot_drain_valid", 64'(wb_ix_valid), 64'd0);

    // Backpressure holds the ip result
    offer(0, 5'd4, 64'hDEAD, 64'h400, 1'b1);
    cyc();
    wb_ix_ready = 1'b0;
    offer(1, 5'd5, 64'hBEEF, 64'h500, 1'b1);
    #1;
    chk("bp_result", wb_ix_result, 64'hDEAD);
    chk("bp_lsp_ready", 64'(s_rdy[1]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("bp_hold_result", wb_ix_result, 64'hDEAD);
      chk("bp_hold_valid", 64'(wb_ix_valid), 64'd1);
      chk("bp_hold_lsp_ready", 64'(s_rdy[1]), 64'd0);
    end
    wb_ix_ready = 1'b1;
    #1;
    chk("bp_release_lsp_ready", 64'(s_rdy[1]), 64'd1);
    cyc(); #1;
    chk("bp_src", 64'(wb_ix_src), 64'd1);
    chk("bp_next_result", wb_ix_result, 64'hBEEF);

    // Fairness: ip and md continuously valid, last winner lsp
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd0; exp_seq[2] = 2'd2; exp_seq[3] = 2'd0;
    offer_rand(0);
    offer_rand(2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      offer_rand(0);
      offer_rand(2);
      #1;
      chk("fair_src", 64'(wb_ix_src), 64'(exp_seq[i]));
    end
    for (int i = 0; i < 3; i++) cyc();

    // wb_en=0 still occupies the slot
    offer(2, 5'd7, 64'h1234, 64'h80, 1'b0);
    cyc(); #1;
    chk("nowb_valid", 64'(wb_ix_valid), 64'd1);
    chk("nowb_dst", 64'(wb_ix_dst), 64'd7);
    chk("nowb_en", 64'(wb_ix_wb_en), 64'd0);
    chk("nowb_pc", wb_ix_pc, 64'h80);

    // Mid-operation reset discards a stalled slot
    wb_ix_ready = 1'b0;
    offer(1, 5'd9, 64'h99, 64'h900, 1'b1);
    cyc(); cyc(); #1;
    chk("mid_stall_valid", 64'(wb_ix_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_lsp_ready", 64'(s_rdy[1]), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(wb_ix_valid), 64'd0);
    offer(0, 5'd10, 64'hAA, 64'hA00, 1'b1);
    #1;
    chk("mid_ip_ready", 64'(s_rdy[0]), 64'd1);
    chk("mid_lsp_ready", 64'(s_rdy[1]), 64'd0);
    cyc(); #1;
    chk("mid_src", 64'(wb_ix_src), 64'd0);
    wb_ix_ready = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      for (int s = 0; s < 3; s++) if ($urandom_range(1, 0) == 1) offer_rand(s);
      wb_ix_ready = ($urandom_range(9, 0) < 7);
      rst = ($urandom_range(249, 0) == 0);
    end
    rst = 1'b0;
    wb_ix_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
